// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_ctrl_pkg
// Brief   : Shared types, constants and byte helpers for mem_ctrl_mc
// Revision: 1.0 - initial release
// ============================================================================
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_READ    = 2'd1,
    ST_WRITE   = 2'd2,
    ST_IO_WAIT = 2'd3
  } state_e;

  // Address window that selects memory-mapped IO (UART and friends)
  localparam logic [1:0] IO_SEL = 2'b11;
  localparam int         IO_HI  = 17;
  localparam int         IO_LO  = 16;

  // Legal transfer lengths in bytes
  localparam logic [2:0] LEN_1 = 3'd1;
  localparam logic [2:0] LEN_2 = 3'd2;
  localparam logic [2:0] LEN_4 = 3'd4;

  // Arbitration modes
  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  function automatic logic [7:0] get_byte(input logic [31:0] d, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    return b;
  endfunction

  function automatic logic [31:0] set_byte(input logic [31:0] d, input logic [1:0] idx,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = d;
    case (idx)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      default: r[31:24] = b;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter
// Brief   : One-hot grant over NUM_CH candidates, fixed priority or round
//           robin; the pointer moves past the owner when its transfer ends
// Revision: 1.0 - initial release
// ============================================================================
module rr_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int ARB_MODE = 0,
  parameter int IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] cand_i,
  input  logic              adv_i,
  input  logic [IDX_W-1:0]  adv_idx_i,
  output logic [NUM_CH-1:0] grant_o
);

  logic [IDX_W-1:0] ptr_q;
  logic             found;

  // Pick the first candidate starting at the pointer (RR) or at index 0 (fixed)
  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!found && cand_i[i] &&
            i == (((ARB_MODE == ARB_RR) ? int'(ptr_q) : 0) + k) % NUM_CH) begin
          grant_o[i] = 1'b1;
          found      = 1'b1;
        end
      end
    end
  end

  // Pointer steps to the slot after the channel that just finished or aborted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (adv_i && ARB_MODE == ARB_RR) begin
      ptr_q <= (adv_idx_i == IDX_W'(NUM_CH - 1)) ? '0 : adv_idx_i + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_ctrl_mc.sv
`default_nettype none
// ============================================================================
// Module  : mem_ctrl_mc
// Brief   : Multi-channel byte-serial RAM/IO controller with arbitration,
//           read flush and IO back-pressure
// Revision: 1.0 - initial release
// ============================================================================
module mem_ctrl_mc
  import mem_ctrl_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int ADDR_W   = 32,
  parameter int ARB_MODE = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rdy,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH-1:0]        ch_wr,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  input  logic [NUM_CH*3-1:0]      ch_len,
  input  logic [NUM_CH*32-1:0]     ch_wdata,
  input  logic [NUM_CH-1:0]        ch_flush,
  output logic [NUM_CH-1:0]        ch_busy,
  output logic [NUM_CH-1:0]        ch_done,
  output logic [31:0]              rdata,
  input  logic [7:0]               ram_in,
  output logic [7:0]               ram_out,
  output logic [ADDR_W-1:0]        ram_addr,
  output logic                     ram_wr,
  input  logic                     io_buffer_full
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_e              state_q;
  logic [IDX_W-1:0]    g_q;
  logic [2:0]          len_q;
  logic [2:0]          cnt_q;      // bytes presented so far (read) / current byte (write)
  logic [31:0]         wdata_q;
  logic [31:0]         rbuf_q;     // read assembly buffer, so an abort leaves rdata intact
  logic [31:0]         rdata_q;
  logic [ADDR_W-1:0]   ram_addr_q;
  logic [7:0]          ram_out_q;
  logic                wr_q;
  logic [NUM_CH-1:0]   busy_q;
  logic [NUM_CH-1:0]   done_q;

  logic [NUM_CH-1:0]   grant;
  logic                adv;
  logic [IDX_W-1:0]    g_idx;
  logic                g_wr;
  logic [ADDR_W-1:0]   g_addr;
  logic [2:0]          g_len;
  logic [31:0]         g_wdata;
  logic [ADDR_W-1:0]   addr_inc;
  logic [1:0]          cap_idx;
  logic [31:0]         rbuf_d;
  logic                rd_end;
  logic                wr_end;

  assign rd_end   = (state_q == ST_READ) && (ch_flush[g_q] || cnt_q == len_q);
  assign wr_end   = (state_q == ST_WRITE) && (cnt_q == len_q - 3'd1);
  assign adv      = rdy && (rd_end || wr_end);
  assign addr_inc = ram_addr_q + ADDR_W'(1);
  assign cap_idx  = cnt_q[1:0] - 2'd1;
  assign rbuf_d   = set_byte(rbuf_q, cap_idx, ram_in);

  rr_arbiter #(
    .NUM_CH   (NUM_CH),
    .ARB_MODE (ARB_MODE),
    .IDX_W    (IDX_W)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .cand_i    (ch_req & ~ch_flush),
    .adv_i     (adv),
    .adv_idx_i (g_q),
    .grant_o   (grant)
  );

  // Mux the granted channel's request fields out of the flattened buses
  always_comb begin
    g_idx   = '0;
    g_wr    = 1'b0;
    g_addr  = '0;
    g_len   = '0;
    g_wdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant[i]) begin
        g_idx   = IDX_W'(i);
        g_wr    = ch_wr[i];
        g_addr  = ch_addr[i*ADDR_W +: ADDR_W];
        g_len   = ch_len[i*3 +: 3];
        g_wdata = ch_wdata[i*32 +: 32];
      end
    end
  end

  // Transfer sequencer: all bus outputs are registered here and frozen by rdy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      g_q        <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      wdata_q    <= '0;
      rbuf_q     <= '0;
      rdata_q    <= '0;
      ram_addr_q <= '0;
      ram_out_q  <= '0;
      wr_q       <= 1'b0;
      busy_q     <= '0;
      done_q     <= '0;
    end else if (rdy) begin
      done_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (|grant) begin
            g_q        <= g_idx;
            len_q      <= g_len;
            wdata_q    <= g_wdata;
            rbuf_q     <= '0;
            cnt_q      <= '0;
            busy_q     <= grant;
            ram_addr_q <= g_addr;
            if (!g_wr) begin
              state_q <= ST_READ;
              wr_q    <= 1'b0;
            end else if (g_addr[IO_HI:IO_LO] == IO_SEL && io_buffer_full) begin
              state_q <= ST_IO_WAIT;
              wr_q    <= 1'b0;
            end else begin
              state_q   <= ST_WRITE;
              wr_q      <= 1'b1;
              ram_out_q <= g_wdata[7:0];
            end
          end
        end
        ST_READ: begin
          if (ch_flush[g_q]) begin
            state_q <= ST_IDLE;
            busy_q  <= '0;
          end else begin
            // Data for the address presented last cycle arrives now
            if (cnt_q != 3'd0) rbuf_q <= rbuf_d;
            if (cnt_q == len_q) begin
              rdata_q <= rbuf_d;
              done_q  <= busy_q;
              busy_q  <= '0;
              state_q <= ST_IDLE;
            end else begin
              ram_addr_q <= addr_inc;
              cnt_q      <= cnt_q + 3'd1;
            end
          end
        end
        ST_WRITE: begin
          if (cnt_q == len_q - 3'd1) begin
            wr_q    <= 1'b0;
            done_q  <= busy_q;
            busy_q  <= '0;
            state_q <= ST_IDLE;
          end else begin
            ram_addr_q <= addr_inc;
            cnt_q      <= cnt_q + 3'd1;
            if (addr_inc[IO_HI:IO_LO] == IO_SEL && io_buffer_full) begin
              state_q <= ST_IO_WAIT;
              wr_q    <= 1'b0;
            end else begin
              wr_q      <= 1'b1;
              ram_out_q <= get_byte(wdata_q, cnt_q[1:0] + 2'd1);
            end
          end
        end
        ST_IO_WAIT: begin
          // Address is already held; issue the pending byte once space frees up
          if (!io_buffer_full) begin
            state_q   <= ST_WRITE;
            wr_q      <= 1'b1;
            ram_out_q <= get_byte(wdata_q, cnt_q[1:0]);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ch_busy  = busy_q;
  assign ch_done  = done_q;
  assign rdata    = rdata_q;
  assign ram_addr = ram_addr_q;
  assign ram_out  = ram_out_q;
  assign ram_wr   = wr_q & rdy;

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl_mc.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_ctrl_mc
// Brief   : Scoreboard bench for mem_ctrl_mc (3 channels, RR and fixed)
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_ctrl_mc;
  import mem_ctrl_pkg::*;

  localparam int NCH = 3;
  localparam int AW  = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            rdy = 1'b1;
  logic            io_buffer_full = 1'b0;
  logic [NCH-1:0]  ch_req = '0, ch_wr = '0, ch_flush = '0, fx_req = '0;
  logic [NCH*AW-1:0] ch_addr = '0;
  logic [NCH*3-1:0]  ch_len = {NCH{3'd1}};
  logic [NCH*32-1:0] ch_wdata = '0;
  logic [7:0]      ram_in = '0;

  logic [NCH-1:0]  ch_busy, ch_done, fx_busy, fx_done;
  logic [31:0]     rdata, fx_rdata;
  logic [7:0]      ram_out, fx_ram_out;
  logic [AW-1:0]   ram_addr, fx_ram_addr;
  logic            ram_wr, fx_ram_wr;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct { int ch; logic [31:0] data; bit chk_data; int cyc; } exp_t;
  typedef struct { logic [31:0] addr; logic [7:0] data; int cyc; } wr_t;
  exp_t exp_q[$];
  exp_t fx_q[$];
  wr_t  wq[$];

  mem_ctrl_mc #(.NUM_CH(NCH), .ADDR_W(AW), .ARB_MODE(1)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .ch_req(ch_req), .ch_wr(ch_wr), .ch_addr(ch_addr), .ch_len(ch_len),
    .ch_wdata(ch_wdata), .ch_flush(ch_flush),
    .ch_busy(ch_busy), .ch_done(ch_done), .rdata(rdata),
    .ram_in(ram_in), .ram_out(ram_out), .ram_addr(ram_addr), .ram_wr(ram_wr),
    .io_buffer_full(io_buffer_full)
  );

  mem_ctrl_mc #(.NUM_CH(NCH), .ADDR_W(AW), .ARB_MODE(0)) dut_fx (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .ch_req(fx_req), .ch_wr(ch_wr), .ch_addr(ch_addr), .ch_len(ch_len),
    .ch_wdata(ch_wdata), .ch_flush(ch_flush),
    .ch_busy(fx_busy), .ch_done(fx_done), .rdata(fx_rdata),
    .ram_in(8'h00), .ram_out(fx_ram_out), .ram_addr(fx_ram_addr), .ram_wr(fx_ram_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM contents: four fixed bytes at 0x100, elsewhere addr[7:0]^0x5A
  function automatic logic [7:0] ram_byte(input logic [31:0] a);
    case (a)
      32'h100: return 8'h11;
      32'h101: return 8'h22;
      32'h102: return 8'h33;
      32'h103: return 8'h44;
      default: return a[7:0] ^ 8'h5A;
    endcase
  endfunction

  always @(posedge clk) ram_in <= ram_byte(ram_addr);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setch(input int ch, input logic wr, input logic [31:0] a,
                       input logic [2:0] l, input logic [31:0] d);
    ch_wr[ch]              = wr;
    ch_addr[ch*AW +: AW]   = a;
    ch_len[ch*3 +: 3]      = l;
    ch_wdata[ch*32 +: 32]  = d;
  endtask

  function automatic exp_t mk(input int ch, input logic [31:0] d, input bit c, input int cy);
    exp_t e;
    e.ch = ch; e.data = d; e.chk_data = c; e.cyc = cy;
    return e;
  endfunction

  function automatic wr_t mkw(input logic [31:0] a, input logic [7:0] d, input int cy);
    wr_t w;
    w.addr = a; w.data = d; w.cyc = cy;
    return w;
  endfunction

  task automatic wait_done(input int ch, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      if (ch_done[ch]) seen = 1'b1;
    end
    ch_req[ch] = 1'b0;
    chk($sformatf("done_seen_ch%0d", ch), 64'(seen), 64'd1);
  endtask

  // Completion monitor for the round-robin instance
  always @(negedge clk) begin : mon_rr
    exp_t e;
    logic [NCH-1:0] oh;
    if (rst_n && ch_done != '0) begin
      if (exp_q.size() == 0) chk("unexpected_done", 64'(ch_done), 64'd0);
      else begin
        e  = exp_q.pop_front();
        oh = NCH'(1) << e.ch;
        chk("done_ch", 64'(ch_done), 64'(oh));
        if (e.chk_data) chk("rdata", 64'(rdata), 64'(e.data));
        if (e.cyc >= 0) chk("done_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Completion monitor for the fixed-priority instance
  always @(negedge clk) begin : mon_fx
    exp_t e;
    logic [NCH-1:0] oh;
    if (rst_n && fx_done != '0) begin
      if (fx_q.size() == 0) chk("fx_unexpected_done", 64'(fx_done), 64'd0);
      else begin
        e  = fx_q.pop_front();
        oh = NCH'(1) << e.ch;
        chk("fx_done_ch", 64'(fx_done), 64'(oh));
        if (e.cyc >= 0) chk("fx_done_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Bus write monitor: every ram_wr cycle must match the next expected byte
  always @(negedge clk) begin : mon_wr
    wr_t w;
    if (rst_n && ram_wr) begin
      if (wq.size() == 0) chk("unexpected_write_addr", 64'(ram_addr), 64'hFFFF_FFFF_FFFF_FFFF);
      else begin
        w = wq.pop_front();
        chk("wr_addr", 64'(ram_addr), 64'(w.addr));
        chk("wr_data", 64'(ram_out), 64'(w.data));
        if (w.cyc >= 0) chk("wr_cycle", 64'(cyc), 64'(w.cyc));
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < NCH; i++)
      if (rst_n && ch_req[i])
        assert (ch_len[i*3 +: 3] inside {LEN_1, LEN_2, LEN_4})
          else $error("illegal ch_len on channel %0d", i);
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int t0;
    int n;

    // Reset state
    step(); step();
    chk("rst_busy", 64'(ch_busy), 64'd0);
    chk("rst_done", 64'(ch_done), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_ram_addr", 64'(ram_addr), 64'd0);
    chk("rst_ram_out", 64'(ram_out), 64'd0);
    chk("rst_ram_wr", 64'(ram_wr), 64'd0);
    rst_n = 1'b1;
    step();

    // 4-byte read on ch0 from 0x100
    setch(0, 1'b0, 32'h100, 3'd4, 32'h0);
    ch_req[0] = 1'b1;
    t0 = cyc;
    exp_q.push_back(mk(0, 32'h4433_2211, 1'b1, t0 + 6));
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("rd_addr_b%0d", k), 64'(ram_addr), 64'(32'h100 + k));
      chk($sformatf("rd_ram_wr_b%0d", k), 64'(ram_wr), 64'd0);
    end
    wait_done(0, 10);
    step();

    // IO write on ch1 with buffer full for 3 cycles
    io_buffer_full = 1'b1;
    setch(1, 1'b1, 32'h0003_0000, 3'd1, 32'h41);
    ch_req[1] = 1'b1;
    wq.push_back(mkw(32'h0003_0000, 8'h41, -1));
    exp_q.push_back(mk(1, 32'h0, 1'b0, -1));
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("io_full_wr_%0d", k), 64'(ram_wr), 64'd0);
      step();
    end
    io_buffer_full = 1'b0;
    wait_done(1, 10);
    step();

    // 2-byte write on ch0 with rdy low for 5 cycles after the first byte
    setch(0, 1'b1, 32'h400, 3'd2, 32'h0000_BEEF);
    ch_req[0] = 1'b1;
    t0 = cyc;
    wq.push_back(mkw(32'h400, 8'hEF, t0 + 1));
    wq.push_back(mkw(32'h401, 8'hBE, t0 + 7));
    exp_q.push_back(mk(0, 32'h0, 1'b0, t0 + 8));
    step();
    step();
    rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("rdy_low_wr_%0d", k), 64'(ram_wr), 64'd0);
      step();
    end
    rdy = 1'b1;
    wait_done(0, 10);
    step();

    // Flush of a ch0 read; pending ch1 read is served right after
    setch(0, 1'b0, 32'h100, 3'd4, 32'h0);
    setch(1, 1'b0, 32'h300, 3'd1, 32'h0);
    ch_req[0] = 1'b1;
    t0 = cyc;
    exp_q.push_back(mk(1, 32'h0000_005A, 1'b1, t0 + 6));
    step();
    ch_req[1] = 1'b1;
    step();
    ch_flush[0] = 1'b1;
    ch_req[0]   = 1'b0;
    step();
    ch_flush[0] = 1'b0;
    chk("flush_busy_idle", 64'(ch_busy), 64'd0);
    chk("flush_rdata_kept", 64'(rdata), 64'h4433_2211);
    step();
    chk("flush_next_grant", 64'(ch_busy), 64'b010);
    wait_done(1, 10);
    step();

    // Reset in the middle of a read
    setch(0, 1'b0, 32'h100, 3'd4, 32'h0);
    ch_req[0] = 1'b1;
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(ch_busy), 64'd0);
    chk("mid_rst_done", 64'(ch_done), 64'd0);
    chk("mid_rst_rdata", 64'(rdata), 64'd0);
    chk("mid_rst_ram_addr", 64'(ram_addr), 64'd0);
    chk("mid_rst_ram_out", 64'(ram_out), 64'd0);
    chk("mid_rst_ram_wr", 64'(ram_wr), 64'd0);
    ch_req[0] = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();

    // First request after reset: 2-byte read on ch2 from 0x1FE
    setch(2, 1'b0, 32'h1FE, 3'd2, 32'h0);
    ch_req[2] = 1'b1;
    t0 = cyc;
    exp_q.push_back(mk(2, 32'h0000_A5A4, 1'b1, t0 + 4));
    wait_done(2, 10);
    step();

    // All channels requesting 1-byte reads: RR order 0,1,2,0; fixed always 0
    setch(0, 1'b0, 32'h200, 3'd1, 32'h0);
    setch(1, 1'b0, 32'h210, 3'd1, 32'h0);
    setch(2, 1'b0, 32'h220, 3'd1, 32'h0);
    ch_req = '1;
    fx_req = '1;
    t0 = cyc;
    exp_q.push_back(mk(0, 32'h5A, 1'b1, t0 + 3));
    exp_q.push_back(mk(1, 32'h4A, 1'b1, t0 + 6));
    exp_q.push_back(mk(2, 32'h7A, 1'b1, t0 + 9));
    exp_q.push_back(mk(0, 32'h5A, 1'b1, t0 + 12));
    for (int k = 1; k <= 4; k++) fx_q.push_back(mk(0, 32'h0, 1'b0, t0 + 3*k));
    n = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      step();
      if (ch_done != '0) n++;
    end
    ch_req = '0;
    fx_req = '0;
    chk("arb_done_count", 64'(n), 64'd4);

    repeat (6) step();
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    chk("fx_q_drained", 64'(fx_q.size()), 64'd0);
    chk("wq_drained", 64'(wq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_ctrl_mc.md
Name: mem_ctrl_mc

Overview:
- Parametrised successor to the two-port instruction/data memory controller.
- Arbitrates NUM_CH requesters (icache, dcache/MEM stage, future prefetcher) onto the single byte-serial RAM/IO bus.
- Sequences 1..4-byte little-endian reads and writes, with per-channel flush of in-flight reads on branch mispredict and IO back-pressure handling.
- Selectable fixed-priority or round-robin arbitration.

Parameters:
- NUM_CH, 2, number of requester channels (1..8); channel 0 is highest priority in fixed mode.
- ADDR_W, 32, address width on channels and RAM bus.
- ARB_MODE, 0, 0 = fixed priority (lowest index wins); 1 = round robin.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- rdy  in  1  global ready; low freezes all state.
- ch_req  in  NUM_CH  per-channel request, level, held until ch_done.
- ch_wr  in  NUM_CH  1 = write, 0 = read.
- ch_addr  in  NUM_CH*ADDR_W  start byte address, flattened (channel i at [i*ADDR_W +: ADDR_W]).
- ch_len  in  NUM_CH*3  byte count, legal values 1, 2, 4.
- ch_wdata  in  NUM_CH*32  write data, byte 0 in [7:0].
- ch_flush  in  NUM_CH  abort the channel's read.
- ch_busy  out  NUM_CH  channel currently granted.
- ch_done  out  NUM_CH  one-cycle completion pulse.
- rdata  out  32  read result, valid with ch_done; unused upper bytes are 0.
- ram_in  in  8  RAM/IO read byte; returns one cycle after its address is presented.
- ram_out  out  8  write byte.
- ram_addr  out  ADDR_W  byte address.
- ram_wr  out  1  1 = write.
- io_buffer_full  in  1  UART tx buffer full.

Behaviour:
- Reset (async, rst_n low): state IDLE; RR pointer 0; all outputs 0, including ch_busy, ch_done, rdata, ram_addr, ram_out and ram_wr. Any transaction in progress is discarded.
- rdy low: every register holds its value. ram_wr is driven as (registered wr & rdy), so a held write is never duplicated.
- FSM states are IDLE, READ, WRITE, IO_WAIT.
- IDLE, arbitration:
  - Candidates are channels with ch_req=1 and ch_flush=0.
  - ARB_MODE 0 picks the lowest index. ARB_MODE 1 picks the first candidate at or after the RR pointer, wrapping.
  - On grant in cycle T0, latch wr/addr/len/wdata, set ch_busy[g], and go to READ or WRITE.
- READ, length L:
  - Byte i address is on ram_addr in cycle T0+1+i, for i = 0..L-1.
  - ram_in is captured into rdata byte i at the end of cycle T0+2+i.
  - ch_done[g] and rdata are valid in cycle T0+L+2; ch_busy drops in the same cycle; the FSM returns to IDLE.
  - ram_wr stays 0 throughout.
- WRITE, length L: byte i is on ram_addr/ram_out with ram_wr=1 in cycle T0+1+i. ch_done[g] is asserted in cycle T0+L+1.
- IO writes (ram_addr[17:16]==2'b11):
  - If io_buffer_full=1 in the cycle a byte would be issued, enter IO_WAIT with ram_wr=0 and the address held.
  - Leave IO_WAIT in the first cycle io_buffer_full=0 and issue that byte. Every later byte is checked the same way.
- Flush:
  - ch_flush[g]=1 during READ aborts at the next edge: FSM to IDLE, ch_busy[g]=0, no ch_done, rdata unchanged.
  - Flush has no effect on writes, which always complete.
  - Flush on a non-granted channel only masks that channel from arbitration.
- RR pointer updates to g+1 (mod NUM_CH) on completion or abort. It does not change in fixed mode.
- Back-to-back: the done cycle is an IDLE cycle, so the next grant is sampled there. The minimum gap is one cycle between one transaction's last bus byte and the next transaction's first bus byte.
- Simultaneous ch_req and ch_flush on the same channel in IDLE: no grant.
- ch_len values outside {1,2,4} are undefined; verification only flags them with an assertion.
- Address arithmetic wraps modulo 2^ADDR_W.

Decomposition:
- Package mem_ctrl_pkg:
  - FSM state enum.
  - IO_SEL constant 2'b11 and the IO address-bit range.
  - Length encodings.
  - ARB_FIXED and ARB_RR constants.
- Sub-module rr_arbiter (NUM_CH, ARB_MODE):
  - Combinational grant plus registered pointer.
  - Inputs: candidate vector and an advance strobe.
  - Output: one-hot grant.

Test Plan:
- Read, ch0, addr 0x100, len 4, RAM bytes 11 22 33 44: ram_addr 0x100..0x103 in cycles T0+1..T0+4; rdata=0x44332211 and ch_done[0] in cycle T0+6.
- Write, ch1, addr 0x30000, len 1, data 0x41, io_buffer_full high for 3 cycles: ram_wr stays 0 while full; then exactly one ram_wr=1 cycle with ram_out=0x41; ch_done[1] follows.
- NUM_CH=3, ARB_MODE 1, all channels requesting continuously with 1-byte reads: grant order is 0,1,2,0. With ARB_MODE 0, channel 0 is granted every time.
- ch0 len-4 read, ch_flush[0] pulsed in cycle T0+2: no ch_done[0]; FSM back in IDLE; pending ch1 request is granted in the following cycle.
- rdy low for 5 cycles mid-write (len 2) with io_buffer_full=0: ram_wr=0 while rdy low; each byte is written exactly once; ch_done is delayed by 5 cycles.
- rst_n asserted mid-read: all outputs 0 immediately; no ch_done; the first request after rst_n is released is served normally.
